schoolmips_top: RTL and testbench

//  Top level of the single-cycle 32-bit MIPS teaching core.
//  - Contains a clock divider, a single-cycle CPU, an instruction ROM and a data RAM.
//  - A combinational debug port lets a board or bench read the PC or any GPR.
//  - Sits directly under the board wrapper or testbench.

---
 rtl/schoolmips_top.sv | 278 +++++++++++++++++++++++++++
 tb/tb_schoolmips_top.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/schoolmips_top.sv
// rtl/schoolmips_top.sv - single-cycle 32-bit MIPS teaching core with clock divider, ROM and RAM
//
// schoolmips_top ports:
//   clkIn      in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   clkDevide  in   4   extra divide exponent, divider tap = DIV_SHIFT + clkDevide
//   clkEnable  in   1   1 = divider counter runs, 0 = counter and CPU clock frozen
//   clk        out  1   CPU clock actually used by the core
//   regAddr    in   5   debug select: 0 = PC, 1..31 = GPR
//   regData    out  32  debug data, combinational
// ROM contents come from ROM_INIT (word i at bits [32*i +: 32]); BYPASS feeds clkIn straight to the core.

module schoolmips_top #(
    parameter int                     ROM_SIZE  = 64,
    parameter int                     RAM_SIZE  = 64,
    parameter int                     DIV_SHIFT = 16,
    parameter bit                     BYPASS    = 1'b0,
    parameter logic [32*ROM_SIZE-1:0] ROM_INIT  = '0
) (
    input  logic        clkIn,
    input  logic        rst,
    input  logic [3:0]  clkDevide,
    input  logic        clkEnable,
    output logic        clk,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData
);
    localparam int ROM_AW = $clog2(ROM_SIZE);
    localparam int RAM_AW = $clog2(RAM_SIZE);

    logic [ROM_AW-1:0] imAddr;
    logic [31:0]       imData;
    logic [RAM_AW-1:0] dmAddr;
    logic              dmWe;
    logic [31:0]       dmWData;
    logic [31:0]       dmRData;

    sm_clk_divider #(.SHIFT(DIV_SHIFT), .bypass(BYPASS)) sm_clk_divider (
        .clkIn (clkIn),
        .rst   (rst),
        .devide(clkDevide),
        .enable(clkEnable),
        .clkOut(clk)
    );

    sm_cpu #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) sm_cpu (
        .clk    (clk),
        .rst    (rst),
        .imAddr (imAddr),
        .imData (imData),
        .dmAddr (dmAddr),
        .dmWe   (dmWe),
        .dmWData(dmWData),
        .dmRData(dmRData),
        .regAddr(regAddr),
        .regData(regData)
    );

    sm_rom #(.SIZE(ROM_SIZE), .AW(ROM_AW), .INIT(ROM_INIT)) sm_rom (
        .a (imAddr),
        .rd(imData)
    );

    sm_ram #(.SIZE(RAM_SIZE), .AW(RAM_AW)) sm_ram (
        .clk(clk),
        .we (dmWe),
        .a  (dmAddr),
        .wd (dmWData),
        .rd (dmRData)
    );
endmodule

// Clock divider: free-running counter on clkIn, output is one selected counter bit.
// Ports: clkIn, rst, devide (extra tap offset), enable (counter run), clkOut.
module sm_clk_divider #(
    parameter int SHIFT  = 16,
    parameter bit bypass = 1'b0
) (
    input  logic       clkIn,
    input  logic       rst,
    input  logic [3:0] devide,
    input  logic       enable,
    output logic       clkOut
);
    logic [31:0] cntr;
    logic [4:0]  tap;

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst)
            cntr <= '0;
        else if (enable)
            cntr <= cntr + 32'd1;
    end

    assign tap    = 5'(SHIFT) + {1'b0, devide};
    assign clkOut = bypass ? clkIn : cntr[tap];
endmodule

// Single-cycle CPU: fetch, decode, execute, writeback all within one clk period.
// Ports: clk, rst, instruction bus (imAddr/imData), data bus (dmAddr/dmWe/dmWData/dmRData),
//        debug port (regAddr/regData).
module sm_cpu #(
    parameter int ROM_AW = 6,
    parameter int RAM_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROM_AW-1:0] imAddr,
    input  logic [31:0]       imData,
    output logic [RAM_AW-1:0] dmAddr,
    output logic              dmWe,
    output logic [31:0]       dmWData,
    input  logic [31:0]       dmRData,
    input  logic [4:0]        regAddr,
    output logic [31:0]       regData
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] F_SRL      = 6'h02;
    localparam logic [5:0] F_ADDU     = 6'h21;
    localparam logic [5:0] F_SUBU     = 6'h23;
    localparam logic [5:0] F_OR       = 6'h25;
    localparam logic [5:0] F_SLTU     = 6'h2B;

    logic [31:0] pc;
    logic [31:0] pcPlus1;
    logic [31:0] pcNext;
    logic [31:0] instr;
    logic [31:0] immSext;
    logic [31:0] sumImm;
    logic [31:0] rd1, rd2, rd3;
    logic        rfWe, dmWeRaw, branchTaken;
    logic [4:0]  rfWa;
    logic [31:0] rfWd;

    wire [5:0]  opcode = instr[31:26];
    wire [4:0]  rs     = instr[25:21];
    wire [4:0]  rt     = instr[20:16];
    wire [4:0]  rd     = instr[15:11];
    wire [4:0]  sa     = instr[10:6];
    wire [5:0]  funct  = instr[5:0];
    wire [15:0] imm    = instr[15:0];

    assign instr   = imData;
    assign imAddr  = pc[ROM_AW-1:0];
    assign immSext = {{16{imm[15]}}, imm};
    // Shared adder: addiu result and load/store effective address.
    assign sumImm  = rd1 + immSext;
    assign dmAddr  = sumImm[RAM_AW+1:2];
    assign dmWData = rd2;
    assign pcPlus1 = pc + 32'd1;
    assign pcNext  = branchTaken ? pcPlus1 + immSext : pcPlus1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= '0;
        else
            pc <= pcNext;
    end

    always_comb begin
        rfWe        = 1'b0;
        rfWa        = rd;
        rfWd        = '0;
        dmWeRaw     = 1'b0;
        branchTaken = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    F_ADDU: begin rfWe = 1'b1; rfWd = rd1 + rd2;           end
                    F_SUBU: begin rfWe = 1'b1; rfWd = rd1 - rd2;           end
                    F_OR:   begin rfWe = 1'b1; rfWd = rd1 | rd2;           end
                    F_SRL:  begin rfWe = 1'b1; rfWd = rd2 >> sa;           end
                    F_SLTU: begin rfWe = 1'b1; rfWd = {31'b0, rd1 < rd2};  end
                    default: ;
                endcase
            end
            OP_ADDIU: begin rfWe = 1'b1; rfWa = rt; rfWd = sumImm;        end
            OP_LUI:   begin rfWe = 1'b1; rfWa = rt; rfWd = {imm, 16'h0};  end
            OP_LW:    begin rfWe = 1'b1; rfWa = rt; rfWd = dmRData;       end
            OP_SW:    dmWeRaw     = 1'b1;
            OP_BEQ:   branchTaken = (rd1 == rd2);
            OP_BNE:   branchTaken = (rd1 != rd2);
            default: ;
        endcase
    end

    // Suppress stores and register writes while in reset so rf/RAM survive a mid-run reset
    // even when clk keeps toggling (bypass mode).
    assign dmWe = dmWeRaw & ~rst;

    sm_register_file rf (
        .clk(clk),
        .ra1(rs),
        .ra2(rt),
        .ra3(regAddr),
        .rd1(rd1),
        .rd2(rd2),
        .rd3(rd3),
        .we (rfWe & ~rst),
        .wa (rfWa),
        .wd (rfWd)
    );

    assign regData = (regAddr == 5'd0) ? pc : rd3;
endmodule

// Register file: three async read ports (two for execution, one for debug), one write port.
// r0 always reads zero and ignores writes. Not reset.
module sm_register_file (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  ra3,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0)
            rf[wa] <= wd;
    end

    assign rd1 = (ra1 != 5'd0) ? rf[ra1] : '0;
    assign rd2 = (ra2 != 5'd0) ? rf[ra2] : '0;
    assign rd3 = (ra3 != 5'd0) ? rf[ra3] : '0;
endmodule

// Instruction ROM: combinational word read, index already reduced modulo SIZE.
// Ports: a (word index), rd (instruction word).
module sm_rom #(
    parameter int                 SIZE = 64,
    parameter int                 AW   = 6,
    parameter logic [32*SIZE-1:0] INIT = '0
) (
    input  logic [AW-1:0] a,
    output logic [31:0]   rd
);
    logic [31:0] rom [SIZE];

    for (genvar i = 0; i < SIZE; i++) begin : g_word
        assign rom[i] = INIT[32*i +: 32];
    end

    assign rd = rom[a];
endmodule

// Data RAM: async read, write on posedge clk. Not reset.
// Ports: clk, we, a (word index), wd (write data), rd (read data).
module sm_ram #(
    parameter int SIZE = 64,
    parameter int AW   = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);
    logic [31:0] ram [SIZE];

    always_ff @(posedge clk) begin
        if (we)
            ram[a] <= wd;
    end

    assign rd = ram[a];
endmodule

// File: tb/tb_schoolmips_top.sv
// tb/tb_schoolmips_top.sv - self-checking bench for schoolmips_top
module tb_schoolmips_top;
    localparam int ROM_SIZE = 64;

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [32*ROM_SIZE-1:0] progB();
        logic [32*ROM_SIZE-1:0] p;
        p = '0;
        p[32*0  +: 32] = encI(6'h09, 5'd0, 5'd2, 16'd5);        // addiu $2,$0,5
        p[32*1  +: 32] = encI(6'h0F, 5'd0, 5'd3, 16'h1234);     // lui   $3,0x1234
        p[32*2  +: 32] = encI(6'h09, 5'd3, 5'd3, 16'h5678);     // addiu $3,$3,0x5678
        p[32*3  +: 32] = encR(5'd0, 5'd3, 5'd4, 5'd4, 6'h02);   // srl   $4,$3,4
        p[32*4  +: 32] = encI(6'h09, 5'd0, 5'd5, 16'hFFFF);     // addiu $5,$0,-1
        p[32*5  +: 32] = encR(5'd0, 5'd5, 5'd6, 5'd0, 6'h2B);   // sltu  $6,$0,$5
        p[32*6  +: 32] = encR(5'd0, 5'd5, 5'd7, 5'd0, 6'h23);   // subu  $7,$0,$5
        p[32*7  +: 32] = encR(5'd5, 5'd5, 5'd8, 5'd0, 6'h21);   // addu  $8,$5,$5
        p[32*8  +: 32] = encI(6'h2B, 5'd0, 5'd3, 16'h0008);     // sw    $3,8($0)
        p[32*9  +: 32] = encI(6'h23, 5'd0, 5'd9, 16'h0008);     // lw    $9,8($0)
        p[32*10 +: 32] = 32'hFFFF_FFFF;                         // unknown opcode
        p[32*11 +: 32] = encR(5'd3, 5'd7, 5'd10, 5'd0, 6'h25);  // or    $10,$3,$7
        p[32*12 +: 32] = encI(6'h09, 5'd0, 5'd2, 16'd3);        // addiu $2,$0,3
        p[32*13 +: 32] = encI(6'h09, 5'd2, 5'd2, 16'hFFFF);     // addiu $2,$2,-1
        p[32*14 +: 32] = encI(6'h05, 5'd2, 5'd0, 16'hFFFE);     // bne   $2,$0,-2
        p[32*15 +: 32] = encI(6'h04, 5'd2, 5'd5, 16'h0003);     // beq   $2,$5,+3
        p[32*16 +: 32] = encI(6'h04, 5'd2, 5'd0, 16'h0001);     // beq   $2,$0,+1
        p[32*17 +: 32] = encI(6'h09, 5'd0, 5'd11, 16'h0077);    // addiu $11,$0,0x77
        p[32*18 +: 32] = encI(6'h09, 5'd0, 5'd12, 16'h0042);    // addiu $12,$0,0x42
        p[32*19 +: 32] = encR(5'd5, 5'd0, 5'd6, 5'd0, 6'h2B);   // sltu  $6,$5,$0
        p[32*20 +: 32] = encI(6'h2B, 5'd0, 5'd7, 16'h0108);     // sw    $7,0x108($0)
        p[32*21 +: 32] = encI(6'h23, 5'd0, 5'd14, 16'h0008);    // lw    $14,8($0)
        p[32*22 +: 32] = encI(6'h23, 5'd0, 5'd15, 16'h000B);    // lw    $15,11($0)
        p[32*23 +: 32] = encI(6'h04, 5'd0, 5'd0, 16'hFFFF);     // beq   $0,$0,-1
        return p;
    endfunction

    function automatic logic [32*ROM_SIZE-1:0] progD();
        logic [32*ROM_SIZE-1:0] p;
        p = '0;
        p[32*0 +: 32] = encI(6'h09, 5'd0, 5'd2, 16'd7);         // addiu $2,$0,7
        p[32*1 +: 32] = encI(6'h09, 5'd2, 5'd2, 16'd1);         // addiu $2,$2,1
        p[32*2 +: 32] = encI(6'h04, 5'd0, 5'd0, 16'hFFFE);      // beq   $0,$0,-2
        return p;
    endfunction

    localparam logic [32*ROM_SIZE-1:0] PROG_B = progB();
    localparam logic [32*ROM_SIZE-1:0] PROG_D = progD();

    logic        clkIn;
    logic        rstB, rstD;
    logic [3:0]  clkDevideB, clkDevideD;
    logic        clkEnableB, clkEnableD;
    logic        clkB, clkD;
    logic [4:0]  regAddrB, regAddrD;
    logic [31:0] regDataB, regDataD;

    schoolmips_top #(.ROM_SIZE(ROM_SIZE), .RAM_SIZE(64), .DIV_SHIFT(16), .BYPASS(1'b1),
                     .ROM_INIT(PROG_B)) dutB (
        .clkIn(clkIn), .rst(rstB), .clkDevide(clkDevideB), .clkEnable(clkEnableB),
        .clk(clkB), .regAddr(regAddrB), .regData(regDataB)
    );

    schoolmips_top #(.ROM_SIZE(ROM_SIZE), .RAM_SIZE(64), .DIV_SHIFT(0), .BYPASS(1'b0),
                     .ROM_INIT(PROG_D)) dutD (
        .clkIn(clkIn), .rst(rstD), .clkDevide(clkDevideD), .clkEnable(clkEnableD),
        .clk(clkD), .regAddr(regAddrD), .regData(regDataD)
    );

    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkIn);
            #1;
        end
    endtask

    typedef struct {
        int          cycles;
        logic [4:0]  addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input int c, input logic [4:0] a, input logic [31:0] e, input string n);
        vec_t v;
        v.cycles = c; v.addr = a; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    // Divider-mode pc after k clkIn edges (CPU edges at k = 2, 6, 10 ...)
    int expPcD [12] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1};

    initial begin
        rstB = 1'b1; rstD = 1'b1;
        clkDevideB = 4'd0; clkDevideD = 4'd1;
        clkEnableB = 1'b1; clkEnableD = 1'b1;
        regAddrB = 5'd0; regAddrD = 5'd0;

        addVec(0, 5'd0,  32'd0,          "reset_pc");
        addVec(1, 5'd0,  32'd1,          "pc_after_1");
        addVec(0, 5'd2,  32'd5,          "addiu");
        addVec(2, 5'd3,  32'h1234_5678,  "lui_addiu");
        addVec(1, 5'd4,  32'h0123_4567,  "srl");
        addVec(1, 5'd5,  32'hFFFF_FFFF,  "addiu_neg");
        addVec(1, 5'd6,  32'd1,          "sltu_true");
        addVec(1, 5'd7,  32'd1,          "subu_wrap");
        addVec(1, 5'd8,  32'hFFFF_FFFE,  "addu_wrap");
        addVec(2, 5'd9,  32'h1234_5678,  "sw_lw");
        addVec(1, 5'd0,  32'd11,         "nop_pc");
        addVec(1, 5'd10, 32'h1234_5679,  "or");
        addVec(1, 5'd2,  32'd3,          "v0_3");
        addVec(1, 5'd2,  32'd2,          "v0_2");
        addVec(1, 5'd0,  32'd13,         "bne_taken_pc");
        addVec(1, 5'd2,  32'd1,          "v0_1");
        addVec(2, 5'd2,  32'd0,          "v0_0");
        addVec(1, 5'd0,  32'd15,         "bne_fallthru_pc");
        addVec(1, 5'd0,  32'd16,         "beq_not_taken_pc");
        addVec(1, 5'd0,  32'd18,         "beq_taken_pc");
        addVec(1, 5'd12, 32'h0000_0042,  "after_skip");
        addVec(1, 5'd6,  32'd0,          "sltu_false");
        addVec(2, 5'd14, 32'd1,          "ram_wrap");
        addVec(1, 5'd15, 32'd1,          "byte_bits_ignored");
        addVec(3, 5'd0,  32'd23,         "halt_loop_pc");

        // Bypass core: reset for 4 cycles, then run the vector table.
        tick(4);
        check("bypass_clk", {31'b0, clkB}, {31'b0, clkIn});
        check("div_reset_pc", regDataD, 32'd0);
        check("div_reset_clk", {31'b0, clkD}, 32'd0);
        rstB = 1'b0;
        foreach (vecs[i]) begin
            tick(vecs[i].cycles);
            regAddrB = vecs[i].addr;
            #1;
            check(vecs[i].name, regDataB, vecs[i].exp);
        end

        // Mid-run reset on the bypass core: pc clears at once, rf kept, restart at ROM[0].
        rstB = 1'b1;
        regAddrB = 5'd0;
        #1;
        check("rst_pc_async", regDataB, 32'd0);
        tick(2);
        regAddrB = 5'd2;
        #1;
        check("rst_rf2_kept", regDataB, 32'd0);
        regAddrB = 5'd3;
        #1;
        check("rst_rf3_kept", regDataB, 32'h1234_5678);
        rstB = 1'b0;
        tick(1);
        regAddrB = 5'd0;
        #1;
        check("restart_pc", regDataB, 32'd1);
        regAddrB = 5'd2;
        #1;
        check("restart_rf2", regDataB, 32'd5);

        // Divider core: DIV_SHIFT=0, clkDevide=1 -> clk = cntr[1].
        rstD = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            check($sformatf("div_clk_k%0d", k), {31'b0, clkD}, 32'((k >> 1) & 1));
            check($sformatf("div_pc_k%0d", k), regDataD, 32'(expPcD[k]));
        end
        regAddrD = 5'd2;
        #1;
        check("div_v0_8", regDataD, 32'd8);
        regAddrD = 5'd0;

        clkEnableD = 1'b0;
        tick(8);
        check("freeze_clk", {31'b0, clkD}, 32'd1);
        check("freeze_pc", regDataD, 32'd1);
        clkEnableD = 1'b1;
        tick(3);
        check("resume_clk", {31'b0, clkD}, 32'd1);
        check("resume_pc", regDataD, 32'd2);
        regAddrD = 5'd2;
        #1;
        check("resume_v0_9", regDataD, 32'd9);
        regAddrD = 5'd0;

        rstD = 1'b1;
        #1;
        check("div_rst_pc", regDataD, 32'd0);
        check("div_rst_clk", {31'b0, clkD}, 32'd0);
        rstD = 1'b0;
        tick(1);
        check("div_restart_pc_k1", regDataD, 32'd0);
        tick(1);
        check("div_restart_pc_k2", regDataD, 32'd1);
        regAddrD = 5'd2;
        #1;
        check("div_restart_v0", regDataD, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
